ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the instruction register's load strobe and data input in the LC-3b pipeline. It runs the instruction-memory read handshake and holds the fetched word while the decode stage is stalled. It also discards in-flight or held fetches on a control-flow redirect. It sits between the PC/branch logic, the instruction memory port and the IR.

---
 rtl/ifetch_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
//
// Instruction-fetch sequencer for the LC-3b pipeline. It runs the
// instruction-memory read handshake, forwards each fetched word to the IR
// with a one-cycle load strobe, and parks the word while decode is stalled.
// On a control-flow redirect it discards the current fetch (or the held
// word) and restarts at the redirect address.
//
// Optional feature macro: IFETCH_PERF_EN
//   defined   -> saturating 16-bit delivered/dropped counters on perf_*
//   undefined -> perf_* tied to 0, no counter flops
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   imem_read     out  read request, held until imem_resp
//   imem_address  out  byte address of the outstanding read
//   imem_rdata    in   instruction word, valid with imem_resp
//   imem_resp     in   one-cycle completion pulse
//   stall         in   decode cannot accept an instruction this cycle
//   flush         in   redirect: discard current fetch, restart at target
//   flush_target  in   redirect byte address (bit 0 forced to 0)
//   load_ir       out  IR load strobe, one cycle per delivered word
//   ir_data       out  word for the IR, valid with load_ir
//   ir_pc         out  address of ir_data, valid with load_ir
//   perf_fetched  out  delivered-instruction count
//   perf_dropped  out  discarded-fetch count
// ---------------------------------------------------------------------------
module ifetch_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] flush_target,
    output logic        load_ir,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_dropped
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;       // next fetch address
    logic [15:0] addr_reg, addr_next;   // outstanding read address
    logic [15:0] hold_reg, hold_next;   // word parked during a stall
    logic        run_reg;               // set by the first edge out of reset

    logic        active;
    logic [15:0] target;
    logic [15:0] addr_plus2;
    logic        fetch_evt;
    logic        drop_evt;

    // Outputs stay quiet while reset is asserted and for the cycle between
    // reset release and the first clean edge; any resp seen then is ignored.
    assign active     = reset_n & run_reg;
    assign target     = flush_target & 16'hFFFE;
    assign addr_plus2 = addr_reg + 16'd2;   // wraps 0xFFFE -> 0x0000

    assign imem_address = addr_reg;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        hold_next  = hold_reg;
        imem_read  = 1'b0;
        load_ir    = 1'b0;
        ir_data    = 16'h0000;
        ir_pc      = 16'h0000;
        fetch_evt  = 1'b0;
        drop_evt   = 1'b0;

        if (active) begin
            case (state_reg)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        if (flush) begin
                            // Word arrives together with a redirect: drop it
                            // and start the new stream right away.
                            drop_evt  = 1'b1;
                            pc_next   = target;
                            addr_next = target;
                        end else if (!stall) begin
                            load_ir   = 1'b1;
                            ir_data   = imem_rdata;
                            ir_pc     = addr_reg;
                            fetch_evt = 1'b1;
                            pc_next   = addr_plus2;
                            addr_next = addr_plus2;
                        end else begin
                            hold_next  = imem_rdata;
                            state_next = HOLD;
                        end
                    end else if (flush) begin
                        // The read in flight cannot be cancelled; remember
                        // where to go and wait for it to complete.
                        pc_next    = target;
                        state_next = DRAIN;
                    end
                end

                HOLD: begin
                    if (flush) begin
                        drop_evt   = 1'b1;
                        pc_next    = target;
                        addr_next  = target;
                        state_next = FETCH;
                    end else if (!stall) begin
                        load_ir    = 1'b1;
                        ir_data    = hold_reg;
                        ir_pc      = addr_reg;
                        fetch_evt  = 1'b1;
                        pc_next    = addr_plus2;
                        addr_next  = addr_plus2;
                        state_next = FETCH;
                    end
                end

                DRAIN: begin
                    imem_read = 1'b1;
                    if (flush) begin
                        pc_next = target;   // latest redirect wins
                    end
                    if (imem_resp) begin
                        drop_evt   = 1'b1;
                        pc_next    = flush ? target : pc_reg;
                        addr_next  = flush ? target : pc_reg;
                        state_next = FETCH;
                    end
                end

                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            pc_reg    <= 16'h0000;
            addr_reg  <= 16'h0000;
            hold_reg  <= 16'h0000;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            hold_reg  <= hold_next;
            run_reg   <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef IFETCH_PERF_EN
    logic [1:0] perf_evt;
    assign perf_evt = {drop_evt, fetch_evt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg <= 16'h0000;
                end else if (perf_evt[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign perf_fetched = g_perf[0].cnt_reg;
    assign perf_dropped = g_perf[1].cnt_reg;
`else
    logic unused_perf;
    assign unused_perf  = fetch_evt ^ drop_evt;
    assign perf_fetched = 16'h0000;
    assign perf_dropped = 16'h0000;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        flush;
    logic [15:0] flush_target;
    logic        load_ir;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic [15:0] perf_fetched;
    logic [15:0] perf_dropped;

    int checks;
    int failures;

    ifetch_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .stall        (stall),
        .flush        (flush),
        .flush_target (flush_target),
        .load_ir      (load_ir),
        .ir_data      (ir_data),
        .ir_pc        (ir_pc),
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        resp;
        logic [15:0] rdata;
        logic        stl;
        logic        fl;
        logic [15:0] tgt;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_load;
        logic [15:0] e_data;
        logic [15:0] e_pc;
        logic [15:0] e_pf;
        logic [15:0] e_pd;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst_n, input logic resp, input logic [15:0] rdata,
        input logic stl, input logic fl, input logic [15:0] tgt,
        input logic e_read, input logic [15:0] e_addr, input logic e_load,
        input logic [15:0] e_data, input logic [15:0] e_pc,
        input logic [15:0] e_pf, input logic [15:0] e_pd);
        vec_t v;
        v.rst_n = rst_n; v.resp = resp; v.rdata = rdata; v.stl = stl;
        v.fl = fl; v.tgt = tgt; v.e_read = e_read; v.e_addr = e_addr;
        v.e_load = e_load; v.e_data = e_data; v.e_pc = e_pc;
        v.e_pf = e_pf; v.e_pd = e_pd;
        return v;
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h1357;
    endfunction

    // Scoreboard for the streaming phase: {address, word} per response.
    logic [31:0] sb_q [$];

    initial begin
        logic [15:0] exp_pf;
        logic [15:0] exp_pd;
        logic [15:0] exp_addr;
        logic [31:0] exp_e;
        int          busy;
        int          lat;
        int          delivered;
        int          cycles;

        checks   = 0;
        failures = 0;

        reset_n      = 1'b0;
        imem_resp    = 1'b0;
        imem_rdata   = 16'h0000;
        stall        = 1'b0;
        flush        = 1'b0;
        flush_target = 16'h0000;

        //            rst resp rdata    stl fl tgt       | rd addr     ld data     pc       pf  pd
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[3]  = mk(1, 1, 16'h1234, 0, 0, 16'h0000,   1, 16'h0000, 1, 16'h1234, 16'h0000, 0, 0);
        vecs[4]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000,   1, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[5]  = mk(1, 1, 16'h5678, 1, 0, 16'h0000,   1, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[6]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[7]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[8]  = mk(1, 0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0002, 1, 16'h5678, 16'h0002, 1, 0);
        vecs[10] = mk(1, 0, 16'h0000, 0, 1, 16'h3001,   1, 16'h0004, 0, 16'h0000, 16'h0000, 2, 0);
        vecs[11] = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h0000, 16'h0000, 2, 0);
        vecs[12] = mk(1, 1, 16'hDEAD, 0, 0, 16'h0000,   1, 16'h0004, 0, 16'h0000, 16'h0000, 2, 0);
        vecs[13] = mk(1, 1, 16'hBEEF, 1, 1, 16'h4444,   1, 16'h3000, 0, 16'h0000, 16'h0000, 2, 1);
        vecs[14] = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   1, 16'h4444, 0, 16'h0000, 16'h0000, 2, 2);
        vecs[15] = mk(1, 0, 16'h0000, 0, 1, 16'h5000,   1, 16'h4444, 0, 16'h0000, 16'h0000, 2, 2);
        vecs[16] = mk(1, 0, 16'h0000, 0, 1, 16'h6000,   1, 16'h4444, 0, 16'h0000, 16'h0000, 2, 2);
        vecs[17] = mk(1, 1, 16'h1111, 0, 1, 16'h7002,   1, 16'h4444, 0, 16'h0000, 16'h0000, 2, 2);
        vecs[18] = mk(1, 1, 16'h2222, 0, 0, 16'h0000,   1, 16'h7002, 1, 16'h2222, 16'h7002, 2, 3);
        vecs[19] = mk(1, 1, 16'h3333, 0, 1, 16'hFFFF,   1, 16'h7004, 0, 16'h0000, 16'h0000, 3, 3);
        vecs[20] = mk(1, 1, 16'hABCD, 0, 0, 16'h0000,   1, 16'hFFFE, 1, 16'hABCD, 16'hFFFE, 3, 4);
        vecs[21] = mk(1, 1, 16'h0F0F, 1, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000, 4, 4);
        vecs[22] = mk(1, 0, 16'h0000, 1, 1, 16'h0200,   0, 16'h0000, 0, 16'h0000, 16'h0000, 4, 4);
        vecs[23] = mk(1, 1, 16'hAAAA, 1, 0, 16'h0000,   1, 16'h0200, 0, 16'h0000, 16'h0000, 4, 5);
        vecs[24] = mk(1, 0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0200, 0, 16'h0000, 16'h0000, 4, 5);
        vecs[25] = mk(0, 0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0200, 0, 16'h0000, 16'h0000, 4, 5);
        vecs[26] = mk(0, 1, 16'h9999, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[27] = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        vecs[28] = mk(1, 1, 16'h5555, 0, 0, 16'h0000,   1, 16'h0000, 1, 16'h5555, 16'h0000, 0, 0);
        vecs[29] = mk(1, 0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0);

        repeat (2) @(posedge clk);

        // ---------------- table-driven cycle vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            reset_n      = vecs[i].rst_n;
            imem_resp    = vecs[i].resp;
            imem_rdata   = vecs[i].rdata;
            stall        = vecs[i].stl;
            flush        = vecs[i].fl;
            flush_target = vecs[i].tgt;
            @(negedge clk);
`ifdef IFETCH_PERF_EN
            exp_pf = vecs[i].e_pf;
            exp_pd = vecs[i].e_pd;
`else
            exp_pf = 16'h0000;
            exp_pd = 16'h0000;
`endif
            checks++;
            if ({imem_read, imem_address, load_ir, ir_data, ir_pc, perf_fetched, perf_dropped} !==
                {vecs[i].e_read, vecs[i].e_addr, vecs[i].e_load, vecs[i].e_data, vecs[i].e_pc, exp_pf, exp_pd}) begin
                failures++;
                $display("FAIL vec%0d got rd=%b addr=%h ld=%b data=%h pc=%h pf=%0d pd=%0d exp rd=%b addr=%h ld=%b data=%h pc=%h pf=%0d pd=%0d",
                         i, imem_read, imem_address, load_ir, ir_data, ir_pc, perf_fetched, perf_dropped,
                         vecs[i].e_read, vecs[i].e_addr, vecs[i].e_load, vecs[i].e_data, vecs[i].e_pc, exp_pf, exp_pd);
            end else begin
                $display("vec%0d ok rd=%b addr=%h ld=%b data=%h pc=%h", i, imem_read, imem_address, load_ir, ir_data, ir_pc);
            end
        end

        // ---------------- streaming phase with scoreboard ----------------
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        imem_resp = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        exp_addr  = 16'h0000;
        busy      = 0;
        lat       = 0;
        delivered = 0;
        cycles    = 0;
        while (delivered < 40 && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            imem_resp  = 1'b0;
            imem_rdata = 16'h0000;
            stall      = ($urandom_range(0, 2) == 0);
            if (imem_read) begin
                if (busy == 0) begin
                    busy = 1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_word(imem_address);
                    busy       = 0;
                    checks++;
                    if (imem_address !== exp_addr) begin
                        failures++;
                        $display("FAIL req_addr got=%h exp=%h", imem_address, exp_addr);
                    end
                    sb_q.push_back({imem_address, imem_rdata});
                    exp_addr = exp_addr + 16'd2;
                end else begin
                    lat--;
                end
            end
            @(negedge clk);
            if (load_ir) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty got pc=%h data=%h exp=none", ir_pc, ir_data);
                end else begin
                    exp_e = sb_q.pop_front();
                    if ({ir_pc, ir_data} !== exp_e) begin
                        failures++;
                        $display("FAIL deliver got pc=%h data=%h exp pc=%h data=%h",
                                 ir_pc, ir_data, exp_e[31:16], exp_e[15:0]);
                    end else begin
                        $display("deliver ok pc=%h data=%h", ir_pc, ir_data);
                    end
                end
                delivered++;
            end
        end

        checks++;
        if (delivered != 40) begin
            failures++;
            $display("FAIL stream_timeout got=%0d exp=40", delivered);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
